// File: rtl/hazard_ctrl.sv
// Pipeline hazard controller: load-use stall, jump flush and multi-cycle MDU freeze.
// Define HAZARD_PERF_CNT_EN to build the stall/flush/freeze performance counters.
module hazard_ctrl #(
  parameter int unsigned MDU_LATENCY = 4
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [4:0]  id_rs,
  input  logic [4:0]  id_rt,
  input  logic        id_uses_rt,
  input  logic        ex_memread,
  input  logic [4:0]  ex_rt,
  input  logic        ex_jump,
  input  logic        mdu_start,
  output logic [5:0]  idex_muxcond,
  output logic        ctrl_zero,
  output logic        pc_write,
  output logic        ifid_write,
  output logic        ifid_flush,
  output logic        mdu_busy,
  output logic [31:0] stall_cnt,
  output logic [31:0] flush_cnt,
  output logic [31:0] freeze_cnt
);

  typedef enum logic [0:0] {StRun, StMduWait} state_e;

  // The entry cycle counts as the first frozen cycle and MDU_WAIT runs until cnt hits 0.
  localparam logic [7:0] CntInit = 8'(MDU_LATENCY - 2);

  state_e     state_q, state_d;
  logic [7:0] cnt_q, cnt_d;
  logic       done_q, done_d;

  logic load_use;
  logic freeze;
  logic flush;
  logic stall;

  assign load_use = ex_memread && (ex_rt != 5'd0) &&
                    ((ex_rt == id_rs) || (id_uses_rt && (ex_rt == id_rt)));

  // done masks the still-asserted mdu_start for one cycle after the freeze ends.
  assign freeze = (state_q == StMduWait) ||
                  ((state_q == StRun) && mdu_start && !done_q && !ex_jump);
  assign flush  = (state_q == StRun) && ex_jump && !freeze;
  assign stall  = (state_q == StRun) && load_use && !freeze && !flush;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= StRun;
      cnt_q   <= 8'd0;
      done_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      done_q  <= done_d;
    end
  end

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    done_d  = 1'b0;
    unique case (state_q)
      StRun: begin
        if (freeze) begin
          state_d = StMduWait;
          cnt_d   = CntInit;
        end
      end
      StMduWait: begin
        if (cnt_q == 8'd0) begin
          state_d = StRun;
          done_d  = 1'b1;
        end else begin
          cnt_d = cnt_q - 8'd1;
        end
      end
      default: state_d = StRun;
    endcase
  end

  always_comb begin
    idex_muxcond = 6'd1;
    ctrl_zero    = 1'b0;
    pc_write     = 1'b1;
    ifid_write   = 1'b1;
    ifid_flush   = 1'b0;
    mdu_busy     = 1'b0;
    if (rst) begin
      idex_muxcond = 6'd0;
      ctrl_zero    = 1'b1;
      pc_write     = 1'b0;
      ifid_write   = 1'b0;
    end else if (freeze) begin
      idex_muxcond = 6'd0;
      pc_write     = 1'b0;
      ifid_write   = 1'b0;
      mdu_busy     = 1'b1;
    end else if (flush) begin
      ctrl_zero  = 1'b1;
      ifid_flush = 1'b1;
    end else if (stall) begin
      ctrl_zero  = 1'b1;
      pc_write   = 1'b0;
      ifid_write = 1'b0;
    end
  end

`ifdef HAZARD_PERF_CNT_EN
  logic [31:0] stall_cnt_q, flush_cnt_q, freeze_cnt_q;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      stall_cnt_q  <= 32'd0;
      flush_cnt_q  <= 32'd0;
      freeze_cnt_q <= 32'd0;
    end else begin
      if (stall && (stall_cnt_q != 32'hFFFF_FFFF)) begin
        stall_cnt_q <= stall_cnt_q + 32'd1;
      end
      if (flush && (flush_cnt_q != 32'hFFFF_FFFF)) begin
        flush_cnt_q <= flush_cnt_q + 32'd1;
      end
      if (freeze && (freeze_cnt_q != 32'hFFFF_FFFF)) begin
        freeze_cnt_q <= freeze_cnt_q + 32'd1;
      end
    end
  end

  assign stall_cnt  = stall_cnt_q;
  assign flush_cnt  = flush_cnt_q;
  assign freeze_cnt = freeze_cnt_q;
`else
  assign stall_cnt  = 32'd0;
  assign flush_cnt  = 32'd0;
  assign freeze_cnt = 32'd0;
`endif

endmodule

// File: tb/tb_hazard_ctrl.sv
// Self-checking bench for hazard_ctrl: directed vector table plus MDU freeze/reset sequences.
module tb_hazard_ctrl;

`ifdef HAZARD_PERF_CNT_EN
  localparam bit PerfEn = 1'b1;
`else
  localparam bit PerfEn = 1'b0;
`endif

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        rst;
  logic [4:0]  id_rs, id_rt, ex_rt;
  logic        id_uses_rt, ex_memread, ex_jump, mdu_start;
  logic [5:0]  idex_muxcond, m2;
  logic        ctrl_zero, pc_write, ifid_write, ifid_flush, mdu_busy;
  logic        cz2, pw2, iw2, fl2, busy2;
  logic [31:0] stall_cnt, flush_cnt, freeze_cnt, sc2, fc2, zc2;

  hazard_ctrl #(.MDU_LATENCY(4)) dut (
    .clk(clk), .rst(rst), .id_rs(id_rs), .id_rt(id_rt), .id_uses_rt(id_uses_rt),
    .ex_memread(ex_memread), .ex_rt(ex_rt), .ex_jump(ex_jump), .mdu_start(mdu_start),
    .idex_muxcond(idex_muxcond), .ctrl_zero(ctrl_zero), .pc_write(pc_write),
    .ifid_write(ifid_write), .ifid_flush(ifid_flush), .mdu_busy(mdu_busy),
    .stall_cnt(stall_cnt), .flush_cnt(flush_cnt), .freeze_cnt(freeze_cnt)
  );

  hazard_ctrl #(.MDU_LATENCY(2)) dut2 (
    .clk(clk), .rst(rst), .id_rs(id_rs), .id_rt(id_rt), .id_uses_rt(id_uses_rt),
    .ex_memread(ex_memread), .ex_rt(ex_rt), .ex_jump(ex_jump), .mdu_start(mdu_start),
    .idex_muxcond(m2), .ctrl_zero(cz2), .pc_write(pw2),
    .ifid_write(iw2), .ifid_flush(fl2), .mdu_busy(busy2),
    .stall_cnt(sc2), .flush_cnt(fc2), .freeze_cnt(zc2)
  );

  typedef struct {
    logic [4:0] rs, rt;
    logic       uses_rt, memread;
    logic [4:0] xrt;
    logic       jump, mdu;
    logic [5:0] e_m;
    logic       e_cz, e_pw, e_iw, e_fl, e_busy;
  } vec_t;

  vec_t vecs[8];

  int pass_cnt = 0;
  int total_cnt = 0;
  int exp_stall = 0, exp_flush = 0, exp_freeze = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    total_cnt++;
    if (act === exp) pass_cnt++;
    else $display("FAIL %s: got %0h expected %0h", name, act, exp);
  endtask

  // Compares dut outputs and advances the counter model by the expected mode.
  task automatic check_out(input string name, input logic [5:0] m, input logic cz,
                           input logic pw, input logic iw, input logic fl, input logic busy);
    chk({name, ".muxcond"}, 32'(idex_muxcond), 32'(m));
    chk({name, ".ctrl_zero"}, 32'(ctrl_zero), 32'(cz));
    chk({name, ".pc_write"}, 32'(pc_write), 32'(pw));
    chk({name, ".ifid_write"}, 32'(ifid_write), 32'(iw));
    chk({name, ".ifid_flush"}, 32'(ifid_flush), 32'(fl));
    chk({name, ".mdu_busy"}, 32'(mdu_busy), 32'(busy));
    if (!rst) begin
      if (fl) exp_flush++;
      else if (busy) exp_freeze++;
      else if (cz && m == 6'd1) exp_stall++;
    end
  endtask

  task automatic check_out2(input string name, input logic [5:0] m, input logic pw,
                            input logic busy);
    chk({name, ".muxcond"}, 32'(m2), 32'(m));
    chk({name, ".pc_write"}, 32'(pw2), 32'(pw));
    chk({name, ".mdu_busy"}, 32'(busy2), 32'(busy));
  endtask

  task automatic check_cnt(input string name);
    chk({name, ".stall_cnt"}, stall_cnt, PerfEn ? 32'(exp_stall) : 32'd0);
    chk({name, ".flush_cnt"}, flush_cnt, PerfEn ? 32'(exp_flush) : 32'd0);
    chk({name, ".freeze_cnt"}, freeze_cnt, PerfEn ? 32'(exp_freeze) : 32'd0);
  endtask

  task automatic next_cycle();
    @(posedge clk);
    #1;
  endtask

  task automatic idle();
    id_rs = 5'd0; id_rt = 5'd0; id_uses_rt = 1'b0; ex_memread = 1'b0;
    ex_rt = 5'd0; ex_jump = 1'b0; mdu_start = 1'b0;
  endtask

  // Holds rst for one cycle, checks the forced outputs, then releases it.
  task automatic do_reset(input string name);
    rst = 1'b1;
    exp_stall = 0; exp_flush = 0; exp_freeze = 0;
    @(negedge clk);
    check_out(name, 6'd0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0);
    check_cnt(name);
    next_cycle();
    rst = 1'b0;
  endtask

  initial begin
    rst = 1'b1;
    idle();
    vecs[0] = '{5'd5, 5'd0, 1'b0, 1'b1, 5'd5, 1'b0, 1'b0, 6'd1, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0};
    vecs[1] = '{5'd0, 5'd0, 1'b1, 1'b1, 5'd0, 1'b0, 1'b0, 6'd1, 1'b0, 1'b1, 1'b1, 1'b0, 1'b0};
    vecs[2] = '{5'd3, 5'd7, 1'b1, 1'b1, 5'd7, 1'b0, 1'b0, 6'd1, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0};
    vecs[3] = '{5'd3, 5'd7, 1'b0, 1'b1, 5'd7, 1'b0, 1'b0, 6'd1, 1'b0, 1'b1, 1'b1, 1'b0, 1'b0};
    vecs[4] = '{5'd5, 5'd5, 1'b1, 1'b0, 5'd5, 1'b0, 1'b0, 6'd1, 1'b0, 1'b1, 1'b1, 1'b0, 1'b0};
    vecs[5] = '{5'd5, 5'd0, 1'b0, 1'b1, 5'd5, 1'b1, 1'b0, 6'd1, 1'b1, 1'b1, 1'b1, 1'b1, 1'b0};
    vecs[6] = '{5'd1, 5'd2, 1'b1, 1'b0, 5'd9, 1'b1, 1'b1, 6'd1, 1'b1, 1'b1, 1'b1, 1'b1, 1'b0};
    vecs[7] = '{5'd4, 5'd6, 1'b1, 1'b1, 5'd9, 1'b0, 1'b0, 6'd1, 1'b0, 1'b1, 1'b1, 1'b0, 1'b0};

    next_cycle();
    // Load-use inputs present during reset must not leak through.
    id_rs = 5'd5; ex_memread = 1'b1; ex_rt = 5'd5;
    do_reset("reset");
    idle();

    for (int i = 0; i < 8; i++) begin
      id_rs = vecs[i].rs; id_rt = vecs[i].rt; id_uses_rt = vecs[i].uses_rt;
      ex_memread = vecs[i].memread; ex_rt = vecs[i].xrt;
      ex_jump = vecs[i].jump; mdu_start = vecs[i].mdu;
      @(negedge clk);
      check_cnt($sformatf("vec%0d", i));
      check_out($sformatf("vec%0d", i), vecs[i].e_m, vecs[i].e_cz, vecs[i].e_pw,
                vecs[i].e_iw, vecs[i].e_fl, vecs[i].e_busy);
      next_cycle();
    end
    idle();
    @(negedge clk);
    check_cnt("table_end");
    next_cycle();

    // Four-cycle freeze; a jump plus load-use in the middle must be ignored.
    do_reset("mdu_rst");
    mdu_start = 1'b1;
    for (int k = 0; k < 5; k++) begin
      if (k == 2) begin ex_jump = 1'b1; ex_memread = 1'b1; ex_rt = 5'd5; id_rs = 5'd5; end
      if (k == 3) begin ex_jump = 1'b0; ex_memread = 1'b0; ex_rt = 5'd0; id_rs = 5'd0; end
      @(negedge clk);
      if (k < 4) check_out($sformatf("mdu%0d", k), 6'd0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1);
      else check_out("mdu_done", 6'd1, 1'b0, 1'b1, 1'b1, 1'b0, 1'b0);
      next_cycle();
    end
    mdu_start = 1'b0;
    @(negedge clk);
    check_out("mdu_after", 6'd1, 1'b0, 1'b1, 1'b1, 1'b0, 1'b0);
    check_cnt("mdu_cnt");
    next_cycle();

    // Reset in the second frozen cycle, then a fresh freeze.
    do_reset("rf_rst0");
    mdu_start = 1'b1;
    @(negedge clk);
    check_out("rf_f1", 6'd0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1);
    next_cycle();
    rst = 1'b1;
    exp_stall = 0; exp_flush = 0; exp_freeze = 0;
    @(negedge clk);
    check_out("rf_mid", 6'd0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0);
    check_cnt("rf_mid");
    next_cycle();
    rst = 1'b0;
    for (int k = 0; k < 5; k++) begin
      @(negedge clk);
      if (k < 4) check_out($sformatf("rf_re%0d", k), 6'd0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1);
      else check_out("rf_done", 6'd1, 1'b0, 1'b1, 1'b1, 1'b0, 1'b0);
      next_cycle();
    end
    mdu_start = 1'b0;
    @(negedge clk);
    check_cnt("rf_cnt");
    next_cycle();

    // MDU_LATENCY=2 instance: two frozen cycles, no retrigger on the held start.
    do_reset("lat2_rst");
    mdu_start = 1'b1;
    for (int k = 0; k < 3; k++) begin
      @(negedge clk);
      if (k < 2) check_out2($sformatf("lat2_%0d", k), 6'd0, 1'b0, 1'b1);
      else check_out2("lat2_done", 6'd1, 1'b1, 1'b0);
      next_cycle();
    end
    mdu_start = 1'b0;
    @(negedge clk);
    check_out2("lat2_after", 6'd1, 1'b1, 1'b0);
    chk("lat2.freeze_cnt", zc2, PerfEn ? 32'd2 : 32'd0);

    $display("%0d/%0d checks passed", pass_cnt, total_cnt);
    $finish;
  end

endmodule
